// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider for the UART baud
// clock tree. It divides i_ref_clk by an active ratio N_act, which is reloaded
// from i_div_ratio only at period boundaries. Ratios 0/1, or i_clk_en=0,
// select bypass, where o_div_clk follows i_ref_clk.
//
// Optional build macro: CLK_DIV_PROG_ODD_DUTY50_EN
//   When this macro is defined, a negedge flop stretches the high phase of
//   odd ratios by half a reference period, which gives exactly 50% duty.
//   When it is undefined, odd ratios run (N-1)/2 high and (N+1)/2 low.
//
// Reset is asynchronous-assert, active-low. The upstream reset synchroniser
// is expected to release i_rst_n synchronously to i_ref_clk, so the first
// enabled posedge after release can safely act as a period boundary.

module clk_div_prog #(
    parameter int RATIO_WIDTH = 8,
    parameter int RST_RATIO   = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    output logic                   o_div_clk,
    output logic                   o_div_active,
    output logic                   o_period_start
);

    typedef enum logic {
        ST_BYPASS = 1'b0,
        ST_DIVIDE = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [RATIO_WIDTH-1:0] cnt_q;
    logic [RATIO_WIDTH-1:0] cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [RATIO_WIDTH-1:0] ratio_d;
    logic                   div_q;
    logic                   div_d;
    logic                   start_q;
    logic                   start_d;

    logic [RATIO_WIDTH-1:0] half_ratio;
    logic [RATIO_WIDTH-1:0] last_cnt;
    logic [RATIO_WIDTH-1:0] cnt_inc;
    logic                   boundary;
    logic                   ratio_divides;
    logic                   div_out;

    // Length of the high phase, and the last count of the current period.
    // N_act is always >= 2 while dividing, so last_cnt cannot underflow
    // when it matters.
    assign half_ratio    = ratio_q >> 1;
    assign last_cnt      = ratio_q - RATIO_WIDTH'(1);
    assign cnt_inc       = cnt_q + RATIO_WIDTH'(1);

    // A requested ratio of 0 or 1 means "pass the reference clock through".
    assign ratio_divides = (i_div_ratio >= RATIO_WIDTH'(2));

    // While bypassing, every enabled edge is a candidate boundary, because
    // the ratio is re-sampled on each posedge. While dividing, only the wrap
    // edge is a boundary, and the divided register is already low there.
    // That is what keeps ratio changes free of runt pulses.
    assign boundary = i_clk_en && ((state_q == ST_BYPASS) || (cnt_q == last_cnt));

    // Mode state register: dividing versus bypassing.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_BYPASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode: disabling forces bypass; otherwise the mode is decided only at a boundary.
    always_comb begin
        state_d = state_q;
        if (!i_clk_en) begin
            state_d = ST_BYPASS;
        end else if (boundary) begin
            state_d = ratio_divides ? ST_DIVIDE : ST_BYPASS;
        end
    end

    // Next counter, active ratio, divided level and period-start pulse.
    always_comb begin
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        div_d   = div_q;
        start_d = 1'b0;
        if (!i_clk_en) begin
            cnt_d = '0;
            div_d = 1'b0;
        end else if (boundary) begin
            // A new period starts here when the sampled ratio divides.
            // A sampled ratio that does not divide holds everything at idle.
            ratio_d = i_div_ratio;
            cnt_d   = '0;
            div_d   = ratio_divides;
            start_d = ratio_divides;
        end else begin
            cnt_d = cnt_inc;
            div_d = (cnt_inc < half_ratio);
        end
    end

    // Datapath registers: all updates happen on the reference posedge.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            ratio_q <= RATIO_WIDTH'(RST_RATIO);
            div_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            div_q   <= div_d;
            start_q <= start_d;
        end
    end

`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
    logic neg_q;
    logic neg_d;

    // Half-cycle stretch for odd ratios. neg_q captures the high level at the
    // negedge of the last high cycle. It then keeps o_div_clk high through
    // the first half of the next cycle.
    always_comb begin
        neg_d = (state_q == ST_DIVIDE) && ratio_q[0] && div_q;
    end

    // Negedge stretch register.
    always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign div_out = div_q | neg_q;
`else
    assign div_out = div_q;
`endif

    // Output mux. The bypass path is gated by reset so that the output sits
    // low while reset is asserted.
    always_comb begin
        o_div_active   = (state_q == ST_DIVIDE);
        o_period_start = start_q;
        o_div_clk      = (state_q == ST_DIVIDE) ? div_out : (i_ref_clk & i_rst_n);
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog. It runs directed scenarios, then a randomized
// run, against a cycle-index reference model. Each posedge and each negedge
// sample is checked, with one line per failing comparison.
module tb_clk_div_prog;

    localparam int RATIO_WIDTH = 8;
    localparam int RST_RATIO   = 2;
`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic                   i_ref_clk;
    logic                   i_rst_n;
    logic                   i_clk_en;
    logic [RATIO_WIDTH-1:0] i_div_ratio;
    logic                   o_div_clk;
    logic                   o_div_active;
    logic                   o_period_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: whether a divided period is running, its ratio, and
    // the index of the current reference cycle within that period.
    bit m_div = 1'b0;
    int m_n   = RST_RATIO;
    int m_k   = 0;

    clk_div_prog #(
        .RATIO_WIDTH(RATIO_WIDTH),
        .RST_RATIO  (RST_RATIO)
    ) dut (
        .i_ref_clk     (i_ref_clk),
        .i_rst_n       (i_rst_n),
        .i_clk_en      (i_clk_en),
        .i_div_ratio   (i_div_ratio),
        .o_div_clk     (o_div_clk),
        .o_div_active  (o_div_active),
        .o_period_start(o_period_start)
    );

    initial begin
        i_ref_clk = 1'b0;
        forever #5 i_ref_clk = ~i_ref_clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one posedge, using the input values present at that edge.
    task automatic model_edge();
        if (!i_rst_n) begin
            m_div = 1'b0;
            m_k   = 0;
            m_n   = RST_RATIO;
        end else if (!i_clk_en) begin
            m_div = 1'b0;
            m_k   = 0;
        end else if (!m_div || m_k == m_n - 1) begin
            m_n   = int'(i_div_ratio);
            m_div = (m_n >= 2);
            m_k   = 0;
        end else begin
            m_k++;
        end
    endtask

    // Expected level just after a posedge: high for the first N/2 cycles, and
    // for odd N with the stretch enabled, the first half of cycle N/2 too.
    function automatic logic exp_clk_pos();
        if (!i_rst_n) return 1'b0;
        if (!m_div)   return 1'b1;
        return (m_k < m_n / 2) || (ODD50 && (m_n % 2 == 1) && (m_k == m_n / 2));
    endfunction

    function automatic logic exp_clk_neg();
        if (!i_rst_n) return 1'b0;
        if (!m_div)   return 1'b0;
        return (m_k < m_n / 2);
    endfunction

    // One reference cycle: update the model at the posedge and check the DUT
    // shortly after it, then check the clock level again after the negedge.
    task automatic step(input string tag);
        @(posedge i_ref_clk);
        model_edge();
        #1;
        check({tag, ".clk_pos"}, o_div_clk, exp_clk_pos());
        check({tag, ".active"},  o_div_active, i_rst_n && m_div);
        check({tag, ".pstart"},  o_period_start, i_rst_n && m_div && (m_k == 0));
        @(negedge i_ref_clk);
        #1;
        check({tag, ".clk_neg"}, o_div_clk, exp_clk_neg());
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Step until the model sits at cycle index k of a divided period, with a bounded wait.
    task automatic wait_k(input string tag, input int k, input int max_cycles);
        bit found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            step(tag);
            found = m_div && (m_k == k);
        end
        n_checks++;
        assert (found) else begin
            n_fail++;
            $error("FAIL %s.wait: observed no cycle index %0d expected within %0d cycles", tag, k, max_cycles);
        end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_clk_en    = 1'b1;
        i_div_ratio = 8'd4;

        // The outputs must stay idle while reset is held.
        steps("reset", 2);
        i_rst_n = 1'b1;

        // Ratio 4: rises on the first edge, then 2 high / 2 low.
        steps("ratio4", 12);

        // Ratio 5: odd duty cycle.
        i_div_ratio = 8'd5;
        steps("ratio5", 15);

        // Change the ratio from 8 to 6 in the middle of a period.
        i_div_ratio = 8'd8;
        wait_k("r8to6", 3, 20);
        i_div_ratio = 8'd6;
        steps("r8to6", 20);

        // Bypass via ratio 1, then ratio 0, then leave bypass with ratio 3.
        i_div_ratio = 8'd1;
        steps("ratio1", 10);
        i_div_ratio = 8'd0;
        steps("ratio0", 6);
        i_div_ratio = 8'd3;
        steps("ratio3", 9);

        // Disable for 10 cycles, then re-enable with ratio 8.
        i_clk_en = 1'b0;
        steps("disabled", 10);
        i_clk_en    = 1'b1;
        i_div_ratio = 8'd8;
        steps("reenable", 16);

        // Assert reset asynchronously in the middle of the high phase.
        wait_k("rstmid", 1, 20);
        @(posedge i_ref_clk);
        model_edge();
        #3;
        i_rst_n = 1'b0;
        model_edge();
        #1;
        check("rstmid.clk_async", o_div_clk, 1'b0);
        check("rstmid.active",    o_div_active, 1'b0);
        check("rstmid.pstart",    o_period_start, 1'b0);
        @(negedge i_ref_clk);
        #1;
        check("rstmid.clk_neg", o_div_clk, 1'b0);
        i_div_ratio = 8'd7;
        steps("rstmid.held", 2);
        i_rst_n = 1'b1;
        steps("rstmid.after", 14);

        // Randomized run: occasional ratio changes and enable toggles.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                i_div_ratio = 8'($urandom_range(0, 12));
            end else if (r < 10) begin
                i_clk_en = ~i_clk_en;
            end else if (r < 13) begin
                i_clk_en = 1'b1;
            end
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
